// File: rtl/musical_score_recorder_if.sv
// Write-side bundle between the score recorder, its control/detector inputs and the score RAM.
// The recorder is the master: it drives the RAM write port and the status outputs.
interface musical_score_recorder_if #(
    parameter int unsigned ADDR_WIDTH  = 7,
    parameter int unsigned TEMPO_WIDTH = 26
);
    logic                   start;
    logic                   stop;
    logic [TEMPO_WIDTH-1:0] tempo;
    logic [3:0]             detected_note;
    logic                   note_valid;
    logic                   wr_en;
    logic [ADDR_WIDTH-1:0]  wr_addr;
    logic [3:0]             wr_data;
    logic                   recording;
    logic                   done;
    logic [ADDR_WIDTH:0]    note_count;

    modport master (
        input  start, stop, tempo, detected_note, note_valid,
        output wr_en, wr_addr, wr_data, recording, done, note_count
    );

    modport slave (
        output start, stop, tempo, detected_note, note_valid,
        input  wr_en, wr_addr, wr_data, recording, done, note_count
    );
endinterface

// File: rtl/musical_score_recorder.sv
// Samples the detected note once per tempo beat and writes the 4-bit note stream into the
// score RAM, closing each song with a 1111 end marker.
module musical_score_recorder #(
    parameter int unsigned ADDR_WIDTH  = 7,
    parameter int unsigned TEMPO_WIDTH = 26
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    musical_score_recorder_if.master   bus
);
    typedef enum logic [1:0] {StIdle, StRecord, StTerminate, StDone} state_e;

    localparam logic [ADDR_WIDTH-1:0]  LastNoteAddr = {{(ADDR_WIDTH-1){1'b1}}, 1'b0};
    localparam logic [3:0]             EndMarker    = 4'hF;
    localparam logic [3:0]             Rest         = 4'h0;

    state_e                 state_q;
    logic [TEMPO_WIDTH-1:0] tempo_q;
    logic [TEMPO_WIDTH-1:0] cnt_q;
    logic                   beat_q;
    logic [3:0]             held_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic                   wr_en_q;
    logic [ADDR_WIDTH-1:0]  wr_addr_q;
    logic [3:0]             wr_data_q;
    logic                   recording_q;
    logic                   done_q;
    logic [ADDR_WIDTH:0]    count_q;

    logic [3:0]             note_in;
    logic [3:0]             beat_note;
    logic [TEMPO_WIDTH-1:0] tempo_eff;
    logic                   beat_hit;

    always_comb begin
        // The detector must never be able to forge the end-of-song marker.
        note_in   = (bus.detected_note == EndMarker) ? Rest : bus.detected_note;
        beat_note = bus.note_valid ? note_in : held_q;
        tempo_eff = (bus.tempo == '0) ? TEMPO_WIDTH'(1) : bus.tempo;
        beat_hit  = (cnt_q == tempo_q - TEMPO_WIDTH'(1));
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q     <= StIdle;
            tempo_q     <= '0;
            cnt_q       <= '0;
            beat_q      <= 1'b0;
            held_q      <= Rest;
            addr_q      <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= Rest;
            recording_q <= 1'b0;
            done_q      <= 1'b0;
            count_q     <= '0;
        end else begin
            wr_en_q <= 1'b0;
            unique case (state_q)
                StIdle, StDone: begin
                    if (bus.start) begin
                        state_q     <= StRecord;
                        tempo_q     <= tempo_eff;
                        cnt_q       <= '0;
                        beat_q      <= 1'b0;
                        held_q      <= Rest;
                        addr_q      <= '0;
                        wr_addr_q   <= '0;
                        count_q     <= '0;
                        recording_q <= 1'b1;
                        done_q      <= 1'b0;
                    end
                end
                StRecord: begin
                    if (beat_hit) begin
                        cnt_q  <= '0;
                        beat_q <= 1'b1;
                    end else begin
                        cnt_q  <= cnt_q + TEMPO_WIDTH'(1);
                        beat_q <= 1'b0;
                    end
                    // beat_q marks the beat cycle; the write lands on the following edge.
                    if (beat_q) begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= addr_q;
                        wr_data_q <= beat_note;
                        addr_q    <= addr_q + ADDR_WIDTH'(1);
                        count_q   <= count_q + (ADDR_WIDTH + 1)'(1);
                        held_q    <= Rest;
                        if (bus.stop || addr_q == LastNoteAddr) begin
                            state_q <= StTerminate;
                        end
                    end else begin
                        if (bus.note_valid) begin
                            held_q <= note_in;
                        end
                        if (bus.stop) begin
                            state_q <= StTerminate;
                        end
                    end
                end
                StTerminate: begin
                    wr_en_q     <= 1'b1;
                    wr_addr_q   <= addr_q;
                    wr_data_q   <= EndMarker;
                    beat_q      <= 1'b0;
                    recording_q <= 1'b0;
                    done_q      <= 1'b1;
                    state_q     <= StDone;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.wr_en      = wr_en_q;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_data    = wr_data_q;
    assign bus.recording  = recording_q;
    assign bus.done       = done_q;
    assign bus.note_count = count_q;
endmodule

// File: tb/tb_musical_score_recorder.sv
// Directed bench for musical_score_recorder: beat timing, note mapping, stop/auto-terminate
// placement of the end marker and mid-song reset.
module tb_musical_score_recorder;
    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    musical_score_recorder_if #(.ADDR_WIDTH(7), .TEMPO_WIDTH(26)) bus ();

    musical_score_recorder #(.ADDR_WIDTH(7), .TEMPO_WIDTH(26)) dut (
        .clk_i   (clk),
        .reset_i (reset_n),
        .bus     (bus)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    // Returns just after the accepting edge E0.
    task automatic do_start(input int tempo);
        bus.tempo = 26'(tempo);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic do_stop();
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
    endtask

    int  nwr;
    bit  found;

    initial begin
        reset_n           = 1'b0;
        bus.start         = 1'b0;
        bus.stop          = 1'b0;
        bus.tempo         = '0;
        bus.detected_note = 4'h0;
        bus.note_valid    = 1'b0;

        // Reset held while control inputs toggle.
        for (int i = 0; i < 3; i++) begin
            bus.start         = ~bus.start;
            bus.stop          = ~bus.stop;
            bus.note_valid    = ~bus.note_valid;
            bus.detected_note = 4'h3;
            bus.tempo         = 26'd4;
            tick();
            check_eq("rst_wr_en", 32'(bus.wr_en), 0);
            check_eq("rst_rec", 32'(bus.recording), 0);
            check_eq("rst_done", 32'(bus.done), 0);
            check_eq("rst_count", 32'(bus.note_count), 0);
            check_eq("rst_addr", 32'(bus.wr_addr), 0);
            check_eq("rst_data", 32'(bus.wr_data), 0);
        end
        bus.start = 1'b0;
        bus.stop = 1'b0;
        bus.note_valid = 1'b0;
        reset_n = 1'b1;
        tick();

        // tempo 4: note held from mid-interval, then a rest interval.
        do_start(4);
        check_eq("t2_rec", 32'(bus.recording), 1);
        tick();
        bus.detected_note = 4'h3;
        bus.note_valid = 1'b1;
        tick();
        bus.note_valid = 1'b0;
        bus.detected_note = 4'h7;
        ticks(2);
        check_eq("t2_e4_wr_en", 32'(bus.wr_en), 0);
        tick();
        check_eq("t2_e5_wr_en", 32'(bus.wr_en), 1);
        check_eq("t2_e5_addr", 32'(bus.wr_addr), 0);
        check_eq("t2_e5_data", 32'(bus.wr_data), 3);
        check_eq("t2_e5_count", 32'(bus.note_count), 1);
        tick();
        check_eq("t2_e6_wr_en", 32'(bus.wr_en), 0);
        ticks(3);
        check_eq("t2_e9_wr_en", 32'(bus.wr_en), 1);
        check_eq("t2_e9_addr", 32'(bus.wr_addr), 1);
        check_eq("t2_e9_data", 32'(bus.wr_data), 0);
        do_stop();
        tick();
        check_eq("t2_term_wr_en", 32'(bus.wr_en), 1);
        check_eq("t2_term_addr", 32'(bus.wr_addr), 2);
        check_eq("t2_term_data", 32'(bus.wr_data), 15);
        tick();
        check_eq("t2_done", 32'(bus.done), 1);
        check_eq("t2_rec_low", 32'(bus.recording), 0);
        check_eq("t2_count", 32'(bus.note_count), 2);

        // tempo 0 behaves as 1: a write every cycle.
        bus.detected_note = 4'h6;
        bus.note_valid = 1'b1;
        do_start(0);
        tick();
        check_eq("t0_e1_wr_en", 32'(bus.wr_en), 0);
        tick();
        check_eq("t0_e2_wr_en", 32'(bus.wr_en), 1);
        check_eq("t0_e2_addr", 32'(bus.wr_addr), 0);
        check_eq("t0_e2_data", 32'(bus.wr_data), 6);
        tick();
        check_eq("t0_e3_addr", 32'(bus.wr_addr), 1);
        do_stop();
        check_eq("t0_e4_addr", 32'(bus.wr_addr), 2);
        bus.note_valid = 1'b0;
        tick();
        check_eq("t0_term_addr", 32'(bus.wr_addr), 3);
        check_eq("t0_term_data", 32'(bus.wr_data), 15);
        tick();
        check_eq("t0_count", 32'(bus.note_count), 3);

        // Stop before the first beat: terminator at address 0.
        do_start(4);
        do_stop();
        tick();
        check_eq("t_early_wr_en", 32'(bus.wr_en), 1);
        check_eq("t_early_addr", 32'(bus.wr_addr), 0);
        check_eq("t_early_data", 32'(bus.wr_data), 15);
        tick();
        check_eq("t_early_done", 32'(bus.done), 1);
        check_eq("t_early_count", 32'(bus.note_count), 0);

        // Detector sending 1111 every cycle must record rests.
        bus.detected_note = 4'hF;
        bus.note_valid = 1'b1;
        do_start(4);
        nwr = 0;
        for (int i = 0; i < 13; i++) begin
            tick();
            if (bus.wr_en) begin
                check_eq("t3_data", 32'(bus.wr_data), 0);
                nwr++;
            end
        end
        check_eq("t3_nwrites", 32'(nwr), 3);
        bus.note_valid = 1'b0;
        do_stop();
        ticks(2);

        // Stop coinciding with the third beat.
        bus.detected_note = 4'h9;
        bus.note_valid = 1'b1;
        do_start(4);
        ticks(12);
        do_stop();
        check_eq("t5_wr_en", 32'(bus.wr_en), 1);
        check_eq("t5_addr", 32'(bus.wr_addr), 2);
        check_eq("t5_data", 32'(bus.wr_data), 9);
        tick();
        check_eq("t5_term_wr_en", 32'(bus.wr_en), 1);
        check_eq("t5_term_addr", 32'(bus.wr_addr), 3);
        check_eq("t5_term_data", 32'(bus.wr_data), 15);
        tick();
        check_eq("t5_done", 32'(bus.done), 1);
        check_eq("t5_count", 32'(bus.note_count), 3);

        // Full song with no stop: auto-terminate at the last address.
        bus.detected_note = 4'h5;
        do_start(2);
        nwr = 0;
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            tick();
            if (bus.wr_en) begin
                if (bus.wr_data == 4'hF) begin
                    check_eq("t4_term_addr", 32'(bus.wr_addr), 127);
                    check_eq("t4_nwrites", 32'(nwr), 127);
                    found = 1'b1;
                end else begin
                    check_eq("t4_addr", 32'(bus.wr_addr), 32'(nwr));
                    check_eq("t4_data", 32'(bus.wr_data), 5);
                    nwr++;
                end
            end
        end
        check_eq("t4_term_seen", 32'(found), 1);
        tick();
        check_eq("t4_done", 32'(bus.done), 1);
        check_eq("t4_rec_low", 32'(bus.recording), 0);
        check_eq("t4_count", 32'(bus.note_count), 127);
        check_eq("t4_wr_en_low", 32'(bus.wr_en), 0);

        // Reset mid-recording, then a fresh start latches the new tempo.
        bus.note_valid = 1'b0;
        do_start(4);
        ticks(25);
        check_eq("t6_pre_wr_en", 32'(bus.wr_en), 1);
        check_eq("t6_pre_addr", 32'(bus.wr_addr), 5);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check_eq("t6_rst_wr_en", 32'(bus.wr_en), 0);
        check_eq("t6_rst_rec", 32'(bus.recording), 0);
        check_eq("t6_rst_count", 32'(bus.note_count), 0);
        check_eq("t6_rst_addr", 32'(bus.wr_addr), 0);
        nwr = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.wr_en) nwr++;
        end
        check_eq("t6_no_term", 32'(nwr), 0);
        bus.detected_note = 4'h2;
        bus.note_valid = 1'b1;
        do_start(2);
        bus.tempo = 26'd7;
        ticks(2);
        check_eq("t6_e2_wr_en", 32'(bus.wr_en), 0);
        tick();
        check_eq("t6_e3_wr_en", 32'(bus.wr_en), 1);
        check_eq("t6_e3_addr", 32'(bus.wr_addr), 0);
        check_eq("t6_e3_data", 32'(bus.wr_data), 2);
        tick();
        check_eq("t6_e4_wr_en", 32'(bus.wr_en), 0);
        tick();
        check_eq("t6_e5_wr_en", 32'(bus.wr_en), 1);
        check_eq("t6_e5_addr", 32'(bus.wr_addr), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/musical_score_recorder.md
Name: musical_score_recorder

Overview:
Write-side counterpart of the song-score ROM path. It samples the player's detected recorder note once per tempo beat and writes the 4-bit note stream into a 128x4 score RAM. The stream uses the same encoding the score loader reads back: 0000 is a rest and 1111 is the end-of-song marker. It sits between the pitch detector and a dual-port score BRAM, so a recorded song can later be replayed as a track.

Parameters:
ADDR_WIDTH, 7, score RAM address width; depth = 2^ADDR_WIDTH, last address reserved for the terminator.
TEMPO_WIDTH, 26, width of the beat period in clk cycles.

Ports:
clk  input  1  system clock
reset  input  1  reset, active-low, synchronous (0 = reset)
start  input  1  begin a recording, single-cycle pulse
stop  input  1  end a recording, single-cycle pulse
tempo_in  input  TEMPO_WIDTH  beat period in clk cycles
detected_note  input  4  note code from the pitch detector
note_valid  input  1  detected_note is valid this cycle
wr_en  output  1  RAM write strobe, registered
wr_addr  output  ADDR_WIDTH  RAM write address, registered
wr_data  output  4  RAM write data, registered
recording  output  1  high in RECORD and TERMINATE
done  output  1  high in DONE
note_count  output  ADDR_WIDTH+1  number of beat notes written, excludes the terminator

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low.
- Reset (reset=0 at a clk edge):
  - state=IDLE.
  - wr_en=0, wr_addr=0, wr_data=0000.
  - recording=0, done=0, note_count=0.
  - Beat counter=0, held_note=0000.
  - Reset mid-recording aborts with no terminator write. RAM contents are untouched.
- States: IDLE, RECORD, TERMINATE, DONE.
- Leaving IDLE or DONE: start=1 moves to RECORD. On that edge:
  - tempo_lat <= tempo_in; tempo_in=0 is treated as 1.
  - Beat counter=0, wr_addr=0, note_count=0, held_note=0000, done=0.
  - start is ignored in RECORD and TERMINATE. stop is ignored in IDLE and DONE.
- Tempo changes: tempo_in changes after start is accepted are ignored until the next start.
- Beat counter in RECORD:
  - Increments each cycle.
  - On count == tempo_lat-1: beat=1 and the counter returns to 0.
  - Beat period is exactly tempo_lat cycles. If start is accepted at edge E0, the first beat is at edge E0+tempo_lat.
- Note capture, non-beat cycle: if note_valid=1, held_note <= map(detected_note).
- map() sends 1111 to 0000, so the detector can never forge the end marker. All other codes pass unchanged.
- Note capture, beat cycle:
  - Note value = map(detected_note) if note_valid, else held_note.
  - On the next edge: wr_en=1, wr_data=that value, wr_addr=current address.
  - The address then increments and held_note clears to 0000.
  - A beat interval with no valid note records a rest.
  - wr_en is a one-cycle pulse; write latency is 1 cycle after the beat.
- note_count increments with each beat write.
- Auto-terminate: when the beat write uses address 2^ADDR_WIDTH-2 (126 at default), the next state is TERMINATE. This caps a song at 127 notes.
- stop in RECORD: next state is TERMINATE. If stop and beat coincide, the beat note is written at edge N+1 and the terminator at N+2.
- TERMINATE lasts one cycle:
  - Writes wr_data=1111 at the next unused address, with wr_en=1 for one cycle.
  - Then goes to DONE: recording=0, done=1, held until the next start or reset.
- Address arithmetic: wr_addr never wraps, because the terminator always lands at 2^ADDR_WIDTH-1 or below.
- Terminator placement: a stop before the first beat writes 1111 at address 0, with note_count=0.

Test Plan:
1. reset=0 for 3 cycles, toggling start, stop and note_valid -> all outputs 0, no wr_en.
2. tempo_in=4, start at E0, note_valid with note 0011 at E0+2 -> wr_en at E0+5, addr 0, data 0011; next beat with no valid note -> addr 1, data 0000 at E0+9.
3. tempo_in=4, detected_note=1111 valid every cycle -> every beat write data is 0000, never 1111.
4. tempo_in=2, no stop -> 127 note writes (addr 0..126), then 1111 at addr 127; done=1, note_count=127, recording falls the cycle after the terminator.
5. tempo_in=4, stop on the same cycle as the 3rd beat -> note written at addr 2, then 1111 at addr 3 the following cycle; note_count=3.
6. Reset asserted mid-RECORD at addr 5 -> no terminator write, outputs cleared; a new start writes from addr 0 with the new tempo_in latched.
